debug_overlay: RTL
==================

# debug_overlay

Frame-synchronous VGA overlay stage downstream of the debug-number glyph generator. Takes the flattened `SEQ_DIGIT`-glyph pixel bitmap (8x8 font rows, one `PIXEL_WIDTH` colour per pixel) and composites it into the live pixel stream at a fixed screen position with integer upscaling. A snapshot register reloads only at frame boundaries, every `UPDATE_FRAMES` frames, so displayed values never tear and stay readable. Output is a 2-cycle pipelined pixel aligned with a delayed `video_on`.

## Interface
- `PIXEL_WIDTH`, 12, colour bits per pixel
- `FONT_WIDTH`, 8, glyph width and height in font pixels
- `SEQ_DIGIT`, 5, glyph count (sign plus 4 BCD digits)
- `X_POS`, 16, left screen column of the box
- `Y_POS`, 16, top screen row of the box
- `SCALE`, 2, upscale factor; power of two in {1, 2, 4, 8}
- `UPDATE_FRAMES`, 30, frames between snapshot reloads; ≥1
- `H_BITS` / `V_BITS`, 10 / 10, counter widths
- `clk` in 1, pixel clock
- `rst_n` in 1, asynchronous active-low reset
- `debug_seq` in `SEQ_DIGIT*FONT_WIDTH*FONT_WIDTH*PIXEL_WIDTH`, glyph bitmap
- `h_cnt` in `H_BITS`, current pixel column
- `v_cnt` in `V_BITS`, current pixel row
- `video_on` in 1, active-area flag
- `frame_start` in 1, one-cycle pulse at the start of each frame
- `bg_pixel` in `PIXEL_WIDTH`, underlying pixel, aligned with `h_cnt`/`v_cnt`
- `out_pixel` out `PIXEL_WIDTH`, composited pixel
- `out_video_on` out 1, `video_on` delayed 2 cycles
- `out_in_box` out 1, pixel lies inside the overlay box, delayed 2 cycles

## Operation
- Bitmap layout of `debug_seq`:
  - Font row r starts at bit `r*SEQ_DIGIT*FONT_WIDTH*PIXEL_WIDTH`.
  - Within a row, pixel (i, k) sits at `(i*FONT_WIDTH+k)*PIXEL_WIDTH`.
  - i = 0 is the least-significant digit; i = `SEQ_DIGIT-1` is the sign.
  - k = `FONT_WIDTH-1` is the leftmost pixel; r = `FONT_WIDTH-1` is the top row.
  - Foreground is all-zeros (black); background is all-ones (white).
- Box geometry:
  - Width W = `SEQ_DIGIT*FONT_WIDTH*SCALE`, height H = `FONT_WIDTH*SCALE`.
  - Hit when `X_POS ≤ h_cnt < X_POS+W` and `Y_POS ≤ v_cnt < Y_POS+H`.
  - Local column c = `(h_cnt-X_POS) >> log2(SCALE)`; local row y = `(v_cnt-Y_POS) >> log2(SCALE)`.
  - Glyph d = `SEQ_DIGIT-1 - c/FONT_WIDTH`, bit k = `FONT_WIDTH-1 - c%FONT_WIDTH`, font row r = `FONT_WIDTH-1 - y`.
  - Comparisons are unsigned at width `max(H_BITS,V_BITS)+1`, so there is no wrap at the screen edges.
- Snapshot control:
  - `snap` register holds `SEQ_DIGIT*FONT_WIDTH*FONT_WIDTH*PIXEL_WIDTH` bits.
  - Frame counter `fcnt` counts 0..`UPDATE_FRAMES-1`.
  - `loaded` flag is cleared by reset.
  - On `frame_start`: if `!loaded` or `fcnt == UPDATE_FRAMES-1`, load `snap <= debug_seq`, set `fcnt <= 0`, set `loaded <= 1`. Otherwise `fcnt <= fcnt+1`.
  - `debug_seq` changes between reloads are ignored.
- Output select (stage 2):
  - `out_video_on` = 0 → `out_pixel` = 0.
  - Outside box → delayed `bg_pixel`.
  - Inside box → `snap` pixel (r, d, k).

## Timing
- Reset (async assert, sync deassert at the source): `snap` all-ones, `fcnt` = 0, `loaded` = 0, all pipeline registers and outputs 0.
- Stage 1 registers: hit, c, y, `bg_pixel`, `video_on`.
- Stage 2 registers: `out_pixel`, `out_in_box`, `out_video_on`.
- Latency is exactly 2 clk cycles from `h_cnt`/`v_cnt` to the outputs.
- A snapshot loaded at edge T is used for pixels sampled at T and later. `frame_start` sits in blanking, so no visible pixel straddles a reload.
- `frame_start` on consecutive cycles: each pulse counts as one frame.
- With `UPDATE_FRAMES = 1`, `snap` reloads on every `frame_start`.
- Reset asserted mid-frame: outputs drop to 0 immediately. After release, output is blank (white box) until the first `frame_start`, which always loads.

## Configuration
- `DEBUG_OVERLAY_TRANSPARENT_EN`:
  - Defined: an in-box pixel equal to all-ones outputs the delayed `bg_pixel`; only foreground (black) pixels are drawn.
  - Undefined: the box is opaque, and white glyph background pixels are output as all-ones.

## Test plan
- Reset release, `debug_seq` = digit "1" pattern, no `frame_start` → in-box `out_pixel` = 12'hFFF, outside box = `bg_pixel`, `out_in_box` correct at (16,16) and (95,31); (96,16) is out of box.
- First `frame_start` after reset → `snap` loads. Font row 7, leftmost pixel of digit 0 (bitmap 00011000, bit 7 = 0) at h = 16+4*16, v = 16 → 12'hFFF. Bit 4 (h = 80+6) → 12'h000. Check 2-cycle latency.
- `UPDATE_FRAMES` = 3, change `debug_seq` after the first load → display unchanged for frame_start pulses 2 and 3, updates on pulse 4 (`fcnt` = 2 → 0).
- Scaling, `SCALE` = 2 → screen pixels (16,16), (17,16), (16,17), (17,17) map to the same font pixel; (18,16) maps to the next font pixel.
- `video_on` = 0 inside box → `out_pixel` = 0 while `out_in_box` still = 1. With `TRANSPARENT_EN`, white in-box pixels equal `bg_pixel` = 12'h0F0.
- Assert `rst_n` mid-line → `out_pixel` = 0 asynchronously. After release, box blank until the next `frame_start`.

Source files
------------

// File: rtl/debug_overlay.sv
// Composites a snapshot of the debug glyph bitmap into the pixel stream with a 2-cycle pipeline.
// Optional macro DEBUG_OVERLAY_TRANSPARENT_EN: white in-box glyph pixels show the background instead.
module debug_overlay #(
  parameter int PIXEL_WIDTH   = 12,
  parameter int FONT_WIDTH    = 8,
  parameter int SEQ_DIGIT     = 5,
  parameter int X_POS         = 16,
  parameter int Y_POS         = 16,
  parameter int SCALE         = 2,
  parameter int UPDATE_FRAMES = 30,
  parameter int H_BITS        = 10,
  parameter int V_BITS        = 10
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [SEQ_DIGIT*FONT_WIDTH*FONT_WIDTH*PIXEL_WIDTH-1:0] debug_seq,
  input  logic [H_BITS-1:0]                                     h_cnt,
  input  logic [V_BITS-1:0]                                     v_cnt,
  input  logic                                                  video_on,
  input  logic                                                  frame_start,
  input  logic [PIXEL_WIDTH-1:0]                                bg_pixel,
  output logic [PIXEL_WIDTH-1:0]                                out_pixel,
  output logic                                                  out_video_on,
  output logic                                                  out_in_box
);

  localparam int SNAP_W = SEQ_DIGIT*FONT_WIDTH*FONT_WIDTH*PIXEL_WIDTH;
  localparam int ROW_W  = SEQ_DIGIT*FONT_WIDTH*PIXEL_WIDTH;
  localparam int CW     = ((H_BITS > V_BITS) ? H_BITS : V_BITS) + 1;
  localparam int SHIFT  = $clog2(SCALE);
  localparam int BOX_W  = SEQ_DIGIT*FONT_WIDTH*SCALE;
  localparam int BOX_H  = FONT_WIDTH*SCALE;
  localparam int FC_W   = $clog2(UPDATE_FRAMES+1);
  localparam int IDX_W  = $clog2(SNAP_W);

  localparam logic [CW-1:0]   X_LO    = CW'(X_POS);
  localparam logic [CW-1:0]   X_HI    = CW'(X_POS + BOX_W);
  localparam logic [CW-1:0]   Y_LO    = CW'(Y_POS);
  localparam logic [CW-1:0]   Y_HI    = CW'(Y_POS + BOX_H);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(UPDATE_FRAMES-1);

  // Snapshot state
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              loaded_q, loaded_d;

  // Stage 1
  logic                   hit_q, hit_d;
  logic [CW-1:0]          c_q, c_d;
  logic [CW-1:0]          y_q, y_d;
  logic [PIXEL_WIDTH-1:0] bg_q, bg_d;
  logic                   von_q, von_d;

  // Stage 2
  logic [PIXEL_WIDTH-1:0] out_pixel_q, out_pixel_d;
  logic                   out_in_box_q, out_in_box_d;
  logic                   out_video_on_q, out_video_on_d;

  logic [CW-1:0]          h_ext, v_ext, dx, dy;
  logic [31:0]            r_v, d_v, k_v;
  logic [IDX_W-1:0]       idx;
  logic [PIXEL_WIDTH-1:0] pix;

  // The very first frame_start always loads so the box leaves its blank state promptly.
  always_comb begin
    snap_d   = snap_q;
    fcnt_d   = fcnt_q;
    loaded_d = loaded_q;
    if (frame_start) begin
      if (!loaded_q || fcnt_q == FC_LAST) begin
        snap_d   = debug_seq;
        fcnt_d   = '0;
        loaded_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  always_comb begin
    h_ext = CW'(h_cnt);
    v_ext = CW'(v_cnt);
    dx    = h_ext - X_LO;
    dy    = v_ext - Y_LO;
    hit_d = (h_ext >= X_LO) && (h_ext < X_HI) && (v_ext >= Y_LO) && (v_ext < Y_HI);
    // Local coordinates are zeroed outside the box so the stage-2 index stays in range.
    c_d   = hit_d ? (dx >> SHIFT) : '0;
    y_d   = hit_d ? (dy >> SHIFT) : '0;
    bg_d  = bg_pixel;
    von_d = video_on;
  end

  always_comb begin
    d_v = 32'(SEQ_DIGIT-1) - 32'(c_q) / 32'(FONT_WIDTH);
    k_v = 32'(FONT_WIDTH-1) - 32'(c_q) % 32'(FONT_WIDTH);
    r_v = 32'(FONT_WIDTH-1) - 32'(y_q);
    idx = IDX_W'(r_v*32'(ROW_W) + (d_v*32'(FONT_WIDTH) + k_v)*32'(PIXEL_WIDTH));
    pix = snap_q[idx +: PIXEL_WIDTH];

    out_in_box_d   = hit_q;
    out_video_on_d = von_q;
    out_pixel_d    = '0;
    if (von_q) begin
      if (!hit_q) begin
        out_pixel_d = bg_q;
      end else begin
`ifdef DEBUG_OVERLAY_TRANSPARENT_EN
        out_pixel_d = (pix == {PIXEL_WIDTH{1'b1}}) ? bg_q : pix;
`else
        out_pixel_d = pix;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q         <= '1;
      fcnt_q         <= '0;
      loaded_q       <= 1'b0;
      hit_q          <= 1'b0;
      c_q            <= '0;
      y_q            <= '0;
      bg_q           <= '0;
      von_q          <= 1'b0;
      out_pixel_q    <= '0;
      out_in_box_q   <= 1'b0;
      out_video_on_q <= 1'b0;
    end else begin
      snap_q         <= snap_d;
      fcnt_q         <= fcnt_d;
      loaded_q       <= loaded_d;
      hit_q          <= hit_d;
      c_q            <= c_d;
      y_q            <= y_d;
      bg_q           <= bg_d;
      von_q          <= von_d;
      out_pixel_q    <= out_pixel_d;
      out_in_box_q   <= out_in_box_d;
      out_video_on_q <= out_video_on_d;
    end
  end

  assign out_pixel    = out_pixel_q;
  assign out_in_box   = out_in_box_q;
  assign out_video_on = out_video_on_q;

endmodule
